// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch path, the load/store unit and the shared memory port.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic        owner;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata, mem_ready,
        output if_rdata, if_valid, ls_rdata, ls_valid, mem_req, mem_we, mem_addr, mem_wdata,
               mem_be, bus_err, owner
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata, mem_ready,
        input  if_rdata, if_valid, ls_rdata, ls_valid, mem_req, mem_we, mem_addr, mem_wdata,
               mem_be, bus_err, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS): LS priority,
// IF anti-starvation after STARVE_LIMIT consecutive LS wins, and a BUSY timeout abort.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int               SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic             TMO_EN     = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [SW-1:0]    r_starve;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_owner;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_ls_rdata;
    logic             r_if_valid;
    logic             r_ls_valid;
    logic             r_bus_err;

    state_t           w_state_nxt;
    logic [SW-1:0]    w_starve_nxt;
    logic [CNT_W-1:0] w_tmo_nxt;
    logic             w_mem_req_nxt;
    logic             w_mem_we_nxt;
    logic [31:0]      w_mem_addr_nxt;
    logic [31:0]      w_mem_wdata_nxt;
    logic [3:0]       w_mem_be_nxt;
    logic             w_owner_nxt;
    logic [31:0]      w_if_rdata_nxt;
    logic [31:0]      w_ls_rdata_nxt;
    logic             w_if_valid_nxt;
    logic             w_ls_valid_nxt;
    logic             w_bus_err_nxt;

    logic w_any_req;
    logic w_grant_ls;
    logic w_tmo_hit;

    assign w_any_req  = bus.if_req | bus.ls_req;
    assign w_grant_ls = bus.ls_req & ~(bus.if_req & (r_starve == STARVE_MAX));
    assign w_tmo_hit  = TMO_EN & (r_tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration and completion logic; everything holds unless a branch overrides it.
    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve;
        w_tmo_nxt       = r_tmo_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_owner_nxt     = r_owner;
        w_if_rdata_nxt  = r_if_rdata;
        w_ls_rdata_nxt  = r_ls_rdata;
        w_if_valid_nxt  = 1'b0;
        w_ls_valid_nxt  = 1'b0;
        w_bus_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt   = ST_BUSY;
                    w_mem_req_nxt = 1'b1;
                    w_tmo_nxt     = {CNT_W{1'b0}};
                    w_owner_nxt   = w_grant_ls;
                    if (w_grant_ls) begin
                        w_mem_we_nxt    = bus.ls_we;
                        w_mem_addr_nxt  = bus.ls_addr;
                        w_mem_wdata_nxt = bus.ls_wdata;
                        w_mem_be_nxt    = bus.ls_be;
                        if (bus.if_req) begin
                            w_starve_nxt = (r_starve == STARVE_MAX) ? STARVE_MAX : r_starve + SW'(1);
                        end else begin
                            w_starve_nxt = {SW{1'b0}};
                        end
                    end else begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = bus.if_addr;
                        w_mem_wdata_nxt = 32'h0000_0000;
                        w_mem_be_nxt    = 4'hF;
                        w_starve_nxt    = {SW{1'b0}};
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
                // READY outranks a timeout falling on the same edge.
                if (bus.mem_ready) begin
                    w_state_nxt   = ST_DONE;
                    w_mem_req_nxt = 1'b0;
                    if (r_owner) begin
                        w_ls_valid_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_ls_rdata_nxt = bus.mem_rdata;
                        end else begin
                            w_ls_rdata_nxt = r_ls_rdata;
                        end
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = bus.mem_rdata;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt   = ST_DONE;
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    if (r_owner) begin
                        w_ls_valid_nxt = 1'b1;
                        w_ls_rdata_nxt = 32'h0000_0000;
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = 32'h0000_0000;
                    end
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered datapath, counters and handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve    <= {SW{1'b0}};
            r_tmo_cnt   <= {CNT_W{1'b0}};
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_be    <= 4'h0;
            r_owner     <= 1'b0;
            r_if_rdata  <= 32'h0000_0000;
            r_ls_rdata  <= 32'h0000_0000;
            r_if_valid  <= 1'b0;
            r_ls_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_starve    <= w_starve_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_owner     <= w_owner_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_ls_rdata  <= w_ls_rdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_ls_valid  <= w_ls_valid_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.owner     = r_owner;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.ls_valid  = r_ls_valid;
    assign bus.bus_err   = r_bus_err;
endmodule
